// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder -- bit-serial WIDTH-bit adder built around one full_adder.
//
// A start request accepted in IDLE captures a, b and cin.  One operand bit
// pair (LSB first) is then fed through the single full_adder per clock, the
// carry being held in a flop between bits.  Sum bits are collected in a shift
// register and the finished word is registered onto sum/cout when the last
// bit is produced.  done pulses for one cycle after that; start is ignored
// while busy.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      add request, sampled only in IDLE
//   a, b   in   WIDTH  operands, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high while in ADD or DONE
//   done   out  1      one-cycle pulse; sum/cout valid from this cycle
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered carry-out, held with sum
// -----------------------------------------------------------------------------

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 sum bits need storing: the final bit comes straight from
  // the full adder on the completing edge.
  logic [WIDTH-2:0] s_sr;
  logic [WIDTH-1:0] s_word;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (count == LAST);
  // Sum word as it stands after the current bit is shifted in.
  assign s_word   = {fa_s, s_sr};

  // Next-state logic for the IDLE -> ADD -> DONE -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ADD;
        end else begin
          state_next = IDLE;
        end
      end
      ADD: begin
        if (last_bit) begin
          state_next = DONE;
        end else begin
          state_next = ADD;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Operand capture, bit-serial datapath and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            count <= '0;
          end else begin
            count <= '0;
          end
        end
        ADD: begin
          carry <= fa_co;
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          s_sr  <= s_word[WIDTH-1:1];
          if (last_bit) begin
            // Counter parks at zero instead of wrapping past WIDTH-1.
            count <= '0;
            sum   <= s_word;
            cout  <= fa_co;
          end else begin
            count <= count + ONE;
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder -- scoreboard bench for serial_adder.
//
// Two instances: WIDTH=8 for directed/random cases and WIDTH=4 for the
// exhaustive back-to-back sweep.  Stimulus pushes a+b+cin into a queue when
// a start is accepted; a monitor per instance pops and compares on done.
// -----------------------------------------------------------------------------

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = 4'h0;
  logic [3:0] b4 = 4'h0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         done_cnt8 = 0;
  int         done_cnt4 = 0;
  int         last_done4 = -1;
  logic [8:0] last8 = 9'h000;
  logic [8:0] exp8[$];
  logic [4:0] exp4[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // WIDTH=8 monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      done_cnt8++;
      if (exp8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL w8_unexpected_done: got done with 0x%0h, required no done", {cout8, sum8});
      end else begin
        last8 = exp8.pop_front();
        check("w8_result", {cout8, sum8}, last8);
      end
    end
  end

  // WIDTH=4 monitor: result plus spacing between consecutive done pulses.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      done_cnt4++;
      if (last_done4 >= 0) check("w4_done_spacing", cyc - last_done4, 6);
      last_done4 = cyc;
      if (exp4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL w4_unexpected_done: got done with 0x%0h, required no done", {cout4, sum4});
      end else begin
        check("w4_result", {cout4, sum4}, exp4.pop_front());
      end
    end
  end

  task automatic wait_idle8();
    int n;
    n = 0;
    @(negedge clk);
    while (busy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w8_idle_wait", busy8, 1'b0);
  endtask

  // One WIDTH=8 add; checks latency, busy length and result hold.  With
  // glitch set, start is re-pulsed in the 2nd ADD cycle and the DONE cycle.
  task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input bit glitch);
    int n;
    int bn;
    bit seen;
    wait_idle8();
    @(posedge clk);
    #1;
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(posedge clk);
    exp8.push_back(9'(ta) + 9'(tb) + 9'(tc));
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    n = 0; bn = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (busy8) bn++;
      if (done8) seen = 1'b1;
      else check("w8_hold_previous", {cout8, sum8}, last8);
      if (glitch && (n == 2 || n == 9)) begin
        start8 = 1'b1;
        a8 = 8'h11;
      end else if (glitch && n == 3) begin
        start8 = 1'b0;
      end
    end
    check("w8_done_latency", n, 9);
    check("w8_busy_cycles", bn, 9);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    check("w8_idle_after_done", busy8, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int nw;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sum8", sum8, 8'h00);
    check("rst_cout8", cout8, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_busy4", busy4, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases
    add8(8'h00, 8'h00, 1'b0, 1'b0);
    add8(8'hFF, 8'h01, 1'b0, 1'b0);
    add8(8'hA5, 8'h5A, 1'b1, 1'b0);
    add8(8'h7F, 8'h01, 1'b0, 1'b0);

    // Start pulses while busy are ignored
    dc = done_cnt8;
    add8(8'h33, 8'h44, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    check("w8_single_done", done_cnt8 - dc, 1);
    check("w8_glitch_result", {cout8, sum8}, 9'h078);

    // Asynchronous reset in the 4th ADD cycle aborts the add
    wait_idle8();
    @(posedge clk);
    #1;
    a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dc = done_cnt8;
    rst_n = 1'b0;
    #1;
    check("abort_sum8", sum8, 8'h00);
    check("abort_cout8", cout8, 1'b0);
    check("abort_busy8", busy8, 1'b0);
    check("abort_done8", done8, 1'b0);
    exp8.delete();
    last8 = 9'h000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt8 - dc, 0);
    add8(8'h03, 8'h04, 1'b0, 1'b0);

    // Random and extreme operands
    for (int i = 0; i < 30; i++) begin
      add8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end
    add8(8'hFF, 8'hFF, 1'b1, 1'b0);

    // WIDTH=4 exhaustive sweep, back-to-back
    @(posedge clk);
    #1;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      a4 = v[7:4]; b4 = v[3:0]; cin4 = v[8]; start4 = 1'b1;
      nw = 0;
      @(negedge clk);
      while (busy4 && nw < 20) begin
        @(negedge clk);
        nw++;
      end
      if (nw >= 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL w4_idle_timeout: busy4=%0b, required 0", busy4);
      end
      @(posedge clk);
      exp4.push_back(5'(a4) + 5'(b4) + 5'(cin4));
      #1;
    end
    start4 = 1'b0;
    repeat (12) @(negedge clk);

    check("w4_done_count", done_cnt4, 512);
    check("w4_queue_empty", exp4.size(), 0);
    check("w8_queue_empty", exp8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
